// File: rtl/mda_pwm_capture.sv
// mda_pwm_capture: eight-channel PWM input capture.
// Measures the high time and period of each PWM_in bit in prescaled ticks.
// Results are read back over an Avalon-MM slave port with one cycle of read latency.
module mda_pwm_capture #(
  parameter int unsigned TICK_DIV = 50
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        chipselect,
  input  logic        read,
  input  logic        write,
  input  logic [4:0]  addr,
  input  logic [31:0] writedata,
  output logic [31:0] readdata,
  input  logic [7:0]  PWM_in
);

  // state | meaning
  // ------+----------------------------------------------------------------
  // IDLE  | no period reference yet (after reset or timeout); waits for a rise
  // MEAS  | counting ticks since the last rise; each rise latches the results
  typedef enum logic {IDLE = 1'b0, MEAS = 1'b1} chan_state_t;

  localparam logic [15:0] TICK_LAST = 16'(TICK_DIV - 1);
  localparam logic [15:0] CNT_MAX   = 16'hFFFF;

  logic [15:0] presc;
  logic        tick;
  logic [7:0]  sync_meta;
  logic [7:0]  sync_s;
  logic [7:0]  sync_p;
  logic [7:0]  rise;
  logic [7:0]  fall;

  chan_state_t state       [8];
  logic [15:0] period_cnt  [8];
  logic [15:0] high_cnt    [8];
  logic [15:0] high_shadow [8];
  logic [15:0] high_reg    [8];
  logic [15:0] period_reg  [8];
  logic [7:0]  valid;
  logic [7:0]  timeout;

  logic        status_wr;
  logic [31:0] rd_mux;
  logic        unused_wdata;

  // With TICK_DIV=1 the prescaler sits at 0, so tick is held high.
  assign tick         = (presc == TICK_LAST);
  assign rise         = sync_s & ~sync_p;
  assign fall         = ~sync_s & sync_p;
  assign status_wr    = chipselect & write & (addr == 5'd16);
  assign unused_wdata = ^writedata[31:8];

  // Shared tick prescaler, counts 0..TICK_DIV-1.
  always_ff @(posedge clk) begin
    if (reset) begin
      presc <= '0;
    end else if (tick) begin
      presc <= '0;
    end else begin
      presc <= presc + 16'd1;
    end
  end

  // Two-flop synchronizer plus a delayed copy for edge detection.
  always_ff @(posedge clk) begin
    if (reset) begin
      sync_meta <= '0;
      sync_s    <= '0;
      sync_p    <= '0;
    end else begin
      sync_meta <= PWM_in;
      sync_s    <= sync_meta;
      sync_p    <= sync_s;
    end
  end

  // Per-channel measurement FSM, result latching and status bits.
  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= '{default: IDLE};
      period_cnt  <= '{default: '0};
      high_cnt    <= '{default: '0};
      high_shadow <= '{default: '0};
      high_reg    <= '{default: '0};
      period_reg  <= '{default: '0};
      valid       <= '0;
      timeout     <= '0;
    end else begin
      for (int i = 0; i < 8; i++) begin
        // Clear first so a timeout set later in this block overrides it.
        if (status_wr && writedata[i]) begin
          timeout[i] <= 1'b0;
        end
        case (state[i])
          IDLE: begin
            if (rise[i]) begin
              period_cnt[i] <= {15'b0, tick};
              high_cnt[i]   <= {15'b0, tick};
              state[i]      <= MEAS;
            end
          end
          MEAS: begin
            if (fall[i]) begin
              high_shadow[i] <= high_cnt[i];
            end
            if (rise[i]) begin
              period_reg[i] <= period_cnt[i];
              high_reg[i]   <= high_shadow[i];
              valid[i]      <= 1'b1;
              period_cnt[i] <= {15'b0, tick};
              high_cnt[i]   <= {15'b0, tick};
            end else if (tick) begin
              if (period_cnt[i] == CNT_MAX) begin
                state[i]   <= IDLE;
                valid[i]   <= 1'b0;
                timeout[i] <= 1'b1;
              end else begin
                period_cnt[i] <= period_cnt[i] + 16'd1;
              end
              if (sync_s[i] && (high_cnt[i] != CNT_MAX)) begin
                high_cnt[i] <= high_cnt[i] + 16'd1;
              end
            end
          end
          default: state[i] <= IDLE;
        endcase
      end
    end
  end

  // Read address decode; the 24-31 window returns period and high time together.
  always_comb begin
    rd_mux = '0;
    case (addr[4:3])
      2'b00: rd_mux = {16'b0, high_reg[addr[2:0]]};
      2'b01: rd_mux = {16'b0, period_reg[addr[2:0]]};
      2'b10: if (addr[2:0] == 3'd0) rd_mux = {16'b0, timeout, valid};
      2'b11: rd_mux = {period_reg[addr[2:0]], high_reg[addr[2:0]]};
      default: rd_mux = '0;
    endcase
  end

  // Registered read data; holds its value between reads.
  always_ff @(posedge clk) begin
    if (reset) begin
      readdata <= '0;
    end else if (chipselect && read) begin
      readdata <= rd_mux;
    end
  end

endmodule

// File: tb/tb_mda_pwm_capture.sv
// Bench for mda_pwm_capture: a TICK_DIV=1 instance for exact counts and a
// TICK_DIV=50 instance for the prescaled measurement.
module tb_mda_pwm_capture;

  logic        clk = 1'b0;
  logic        reset;
  logic        cs, rd, wr;
  logic [4:0]  addr;
  logic [31:0] wdata, rdata;
  logic [7:0]  pwm;

  logic        cs50, rd50, wr50;
  logic [4:0]  addr50;
  logic [31:0] wdata50, rdata50;
  logic [7:0]  pwm50;

  int n_checks = 0;
  int n_fail   = 0;

  // PWM pattern generators: mode 0 = low, 1 = high, 2 = PWM (hi cycles high out of per).
  int gen_hi [8];
  int gen_per[8];
  int gen_ph [8];
  int gen_mode[8];
  int ph50;

  typedef struct {
    int          ch;
    int          hi;
    int          per;
    logic [31:0] exp_hi;
    logic [31:0] exp_per;
  } vec_t;
  vec_t vecs[8];

  int m_hi [8];
  int m_per[8];

  always #5 clk = ~clk;

  mda_pwm_capture #(.TICK_DIV(1)) dut (
    .clk(clk), .reset(reset), .chipselect(cs), .read(rd), .write(wr),
    .addr(addr), .writedata(wdata), .readdata(rdata), .PWM_in(pwm)
  );

  mda_pwm_capture #(.TICK_DIV(50)) dut50 (
    .clk(clk), .reset(reset), .chipselect(cs50), .read(rd50), .write(wr50),
    .addr(addr50), .writedata(wdata50), .readdata(rdata50), .PWM_in(pwm50)
  );

  initial begin
    pwm = '0;
    for (int i = 0; i < 8; i++) begin
      gen_hi[i] = 1; gen_per[i] = 2; gen_ph[i] = 0; gen_mode[i] = 0;
    end
    forever begin
      @(negedge clk);
      for (int i = 0; i < 8; i++) begin
        case (gen_mode[i])
          1: pwm[i] = 1'b1;
          2: begin
            pwm[i]    = (gen_ph[i] < gen_hi[i]);
            gen_ph[i] = (gen_ph[i] + 1) % gen_per[i];
          end
          default: pwm[i] = 1'b0;
        endcase
      end
    end
  end

  initial begin
    pwm50 = '0;
    ph50  = 0;
    forever begin
      @(negedge clk);
      pwm50[0] = (ph50 < 1500);
      ph50     = (ph50 + 1) % 5000;
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic check_range(input string name, input logic [31:0] act, input int lo, input int hi);
    n_checks++;
    if (act < lo || act > hi) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d..%0d", name, act, lo, hi);
    end
  endtask

  task automatic wait_cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic bus_read(input logic [4:0] a, output logic [31:0] d);
    cs = 1'b1; rd = 1'b1; addr = a;
    @(posedge clk); #1;
    cs = 1'b0; rd = 1'b0;
    d = rdata;
  endtask

  task automatic bus_write(input logic [4:0] a, input logic [31:0] d);
    cs = 1'b1; wr = 1'b1; addr = a; wdata = d;
    @(posedge clk); #1;
    cs = 1'b0; wr = 1'b0;
  endtask

  task automatic read50(input logic [4:0] a, output logic [31:0] d);
    cs50 = 1'b1; rd50 = 1'b1; addr50 = a;
    @(posedge clk); #1;
    cs50 = 1'b0; rd50 = 1'b0;
    d = rdata50;
  endtask

  task automatic set_ch(input int ch, input int hi, input int per);
    gen_hi[ch] = hi; gen_per[ch] = per; gen_ph[ch] = 0; gen_mode[ch] = 2;
  endtask

  task automatic wait_phase(input int ch, input int ph);
    bit found = 1'b0;
    for (int k = 0; k < 5000 && !found; k++) begin
      @(posedge clk); #1;
      if (gen_ph[ch] == ph) found = 1'b1;
    end
    n_checks++;
    if (!found) begin
      n_fail++;
      $display("FAIL wait_phase ch%0d: phase %0d not reached, expected within 5000 cycles", ch, ph);
    end
  endtask

  initial begin
    logic [31:0] v, hold;
    int maxper;

    vecs[0] = '{0, 10, 200, 32'd10, 32'd200};
    vecs[1] = '{1, 20, 200, 32'd20, 32'd200};
    vecs[2] = '{2, 30, 200, 32'd30, 32'd200};
    vecs[3] = '{3, 40, 200, 32'd40, 32'd200};
    vecs[4] = '{4, 50, 200, 32'd50, 32'd200};
    vecs[5] = '{5, 60, 200, 32'd60, 32'd200};
    vecs[6] = '{6, 70, 200, 32'd70, 32'd200};
    vecs[7] = '{7, 80, 200, 32'd80, 32'd200};

    reset = 1'b1;
    cs = 0; rd = 0; wr = 0; addr = '0; wdata = '0;
    cs50 = 0; rd50 = 0; wr50 = 0; addr50 = '0; wdata50 = '0;
    wait_cycles(3);
    reset = 1'b0;

    // Reset state.
    check("reset_readdata", rdata, 32'h0);
    bus_read(5'd16, v); check("reset_status", v, 32'h0);
    bus_read(5'd0,  v); check("reset_high0", v, 32'h0);
    bus_read(5'd24, v); check("reset_pair0", v, 32'h0);

    // Basic capture: 30 high / 70 low on channel 0.
    set_ch(0, 30, 100);
    wait_cycles(350);
    bus_read(5'd0,  v); check("basic_high", v, 32'd30);
    bus_read(5'd8,  v); check("basic_period", v, 32'd100);
    bus_read(5'd24, v); check("basic_pair", v, 32'h0064001E);
    bus_read(5'd16, v); check("basic_status", v, 32'h00000001);

    // Independent channels from the vector table.
    for (int i = 0; i < 8; i++) set_ch(vecs[i].ch, vecs[i].hi, vecs[i].per);
    wait_cycles(3 * 200 + 20);
    for (int i = 0; i < 8; i++) begin
      bus_read(5'(vecs[i].ch), v);      check($sformatf("tbl_high%0d", i), v, vecs[i].exp_hi);
      bus_read(5'(8 + vecs[i].ch), v);  check($sformatf("tbl_period%0d", i), v, vecs[i].exp_per);
      bus_read(5'(24 + vecs[i].ch), v);
      check($sformatf("tbl_pair%0d", i), v, {vecs[i].exp_per[15:0], vecs[i].exp_hi[15:0]});
    end
    bus_read(5'd16, v); check("tbl_status", v, 32'h000000FF);

    // Randomised duty/period on all channels against the length model.
    for (int it = 0; it < 6; it++) begin
      maxper = 0;
      for (int i = 0; i < 8; i++) begin
        m_hi[i]  = int'($urandom_range(2, 120));
        m_per[i] = m_hi[i] + int'($urandom_range(2, 120));
        if (m_per[i] > maxper) maxper = m_per[i];
        set_ch(i, m_hi[i], m_per[i]);
      end
      wait_cycles(3 * maxper + 20);
      for (int i = 0; i < 8; i++) begin
        bus_read(5'(24 + i), v);
        check($sformatf("rand%0d_pair%0d", it, i), v, {16'(m_per[i]), 16'(m_hi[i])});
      end
      bus_read(5'd16, v); check($sformatf("rand%0d_status", it), v, 32'h000000FF);
    end

    // Reset mid-period while channel 0 is low.
    set_ch(0, 30, 100);
    wait_phase(0, 50);
    reset = 1'b1;
    wait_cycles(1);
    reset = 1'b0;
    check("midrst_readdata", rdata, 32'h0);
    bus_read(5'd16, v); check("midrst_status", v, 32'h0);
    wait_phase(0, 10);
    bus_read(5'd0, v);  check("midrst_first_high", v, 32'h0);
    bus_read(5'd16, v); check("midrst_first_valid0", {31'b0, v[0]}, 32'h0);
    wait_phase(0, 10);
    bus_read(5'd24, v); check("midrst_second_pair", v, 32'h0064001E);
    bus_read(5'd16, v); check("midrst_second_valid0", {31'b0, v[0]}, 32'h1);

    // Unmapped reads, ignored writes and idle-bus hold.
    bus_read(5'd17, v); check("unmapped17", v, 32'h0);
    bus_read(5'd20, v); check("unmapped20", v, 32'h0);
    bus_write(5'd0, 32'hFFFF_FFFF);
    bus_read(5'd24, hold); check("pair_after_ignored_write", hold, 32'h0064001E);
    wait_cycles(5);
    check("hold_idle", rdata, hold);
    cs = 1'b1; addr = 5'd17;
    wait_cycles(2);
    cs = 1'b0;
    check("hold_cs_no_read", rdata, hold);

    // Timeout and recovery on channel 3: hold the pin high after valid PWM.
    set_ch(3, 10, 40);
    wait_cycles(200);
    wait_phase(3, 5);
    gen_mode[3] = 1;
    wait_cycles(65500);
    bus_read(5'd16, v); check("to_not_yet", v, 32'h000000FF);
    wait_cycles(60);
    bus_read(5'd16, v); check("to_status", v, 32'h000008F7);
    bus_read(5'd3,  v); check("to_high_kept", v, 32'd10);
    bus_read(5'd11, v); check("to_period_kept", v, 32'd40);
    bus_write(5'd16, 32'h0000_00F7);
    bus_read(5'd16, v); check("w1c_other_bits", v, 32'h000008F7);
    bus_write(5'd16, 32'h0000_0008);
    bus_read(5'd16, v); check("w1c_clear3", v, 32'h000000F7);
    gen_ph[3] = 0; gen_mode[3] = 2;
    wait_cycles(50);
    bus_read(5'd16, v); check("resume_one_rise", v, 32'h000000F7);
    wait_cycles(40);
    bus_read(5'd16, v); check("resume_two_rises", v, 32'h000000FF);
    bus_read(5'd27, v); check("resume_pair3", v, {16'd40, 16'd10});

    // Prescaled instance: 1500/5000 cycles at 50 cycles per tick.
    read50(5'd0,  v); check_range("presc_high", v, 29, 31);
    read50(5'd8,  v); check_range("presc_period", v, 99, 101);
    read50(5'd16, v); check("presc_status", v, 32'h00000001);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
